// File: rtl/uart_frame_sender.sv
// Frames a 6x16-bit sensor sample as HDR0, HDR1, 12 payload bytes and an 8-bit checksum,
// driving the UART's level-held send / pulsed done handshake one byte at a time.
module uart_frame_sender #(
   parameter logic [7:0] HDR0       = 8'h55,
   parameter logic [7:0] HDR1       = 8'hAA,
   parameter int         GAP_CYCLES = 4,
   parameter int         TIMEOUT    = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [95:0] sample_data,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   input  logic        tx_done,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err,
   output logic [7:0]  drop_cnt
);

   localparam int          GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
   localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);
   localparam logic [16:0] TMO_LAST = 17'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEND = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]  state;
   logic [95:0] sample_reg;
   logic [3:0]  byte_idx;
   logic [7:0]  checksum;
   logic [16:0] tmo_cnt;
   logic [15:0] gap_cnt;
   logic [7:0]  cur_byte;
   logic [6:0]  shamt;

   always_comb begin
      cur_byte = checksum;
      shamt    = '0;
      if (byte_idx == 4'd0) begin
         cur_byte = HDR0;
      end else if (byte_idx == 4'd1) begin
         cur_byte = HDR1;
      end else if (byte_idx <= 4'd13) begin
         // payload byte k = byte_idx-2 lives at bit 88-8k (word0 high byte first)
         shamt    = 7'd104 - {byte_idx, 3'b000};
         cur_byte = sample_reg[shamt +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         sample_reg <= '0;
         byte_idx   <= '0;
         checksum   <= '0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
         tx_data    <= '0;
         tx_send    <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (sample_valid && state != S_IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         case (state)
            S_IDLE: begin
               if (sample_valid) begin
                  sample_reg <= sample_data;
                  byte_idx   <= '0;
                  checksum   <= '0;
                  state      <= S_SEND;
               end
            end
            S_SEND: begin
               tx_data <= cur_byte;
               tx_send <= 1'b1;
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_done) begin
                  checksum <= checksum + tx_data;
                  tx_send  <= 1'b0;
                  byte_idx <= byte_idx + 4'd1;
                  gap_cnt  <= '0;
                  state    <= (byte_idx == 4'd14) ? S_DONE : S_GAP;
               end else if (tmo_cnt == TMO_LAST) begin
                  tx_send <= 1'b0;
                  state   <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 17'd1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_SEND;
               else                     gap_cnt <= gap_cnt + 16'd1;
            end
            S_DONE:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);
   assign frame_err  = (state == S_ERR);

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: randomized samples, a UART stub, and a scoreboard fed by a
// frame model built directly from the header/payload/checksum rules.
module tb_uart_frame_sender;

   localparam int GAP = 1;
   localparam int TMO = 50;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sample_valid = 1'b0;
   logic [95:0] sample_data = '0;
   logic        tx_done = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_send;
   logic        busy;
   logic        frame_done;
   logic        frame_err;
   logic [7:0]  drop_cnt;

   uart_frame_sender #(
      .HDR0(8'h55), .HDR1(8'hAA), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
      .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int exp_drop = 0;

   int stub_delay = 20;
   int withhold_idx = -1;

   int mon_rises = 0;
   int mon_idx = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int high_run = 0;
   int last_high = 0;
   int low_run = 0;
   logic [7:0] last_byte = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic byte_q_t build_frame(input logic [95:0] s);
      byte_q_t q;
      logic [15:0] w;
      int sum;
      q.push_back(8'h55);
      q.push_back(8'hAA);
      for (int i = 0; i < 6; i++) begin
         w = 16'(s >> (80 - 16 * i));
         q.push_back(w[15:8]);
         q.push_back(w[7:0]);
      end
      sum = 0;
      foreach (q[i]) sum += int'(q[i]);
      q.push_back(8'(sum % 256));
      return q;
   endfunction

   // UART stub: pulses tx_done stub_delay cycles after tx_send rises, or never for withhold_idx
   initial begin
      int cnt = 0;
      int cur = 0;
      int sidx = 0;
      logic prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (busy !== 1'b1) sidx = 0;
         if (tx_send === 1'b1 && !prev) begin
            cur = sidx;
            sidx++;
            cnt = 0;
         end
         if (tx_send === 1'b1 && cur != withhold_idx) begin
            if (cnt == stub_delay) tx_done = 1'b1;
            cnt++;
         end
         prev = (tx_send === 1'b1);
      end
   end

   // Monitor / scoreboard, sampling on the falling edge
   initial begin
      logic prev_send = 1'b0;
      logic [7:0] prev_data = '0;
      forever begin
         @(negedge clk);
         if (busy === 1'b0) mon_idx = 0;
         if (frame_done === 1'b1) done_cnt++;
         if (frame_err === 1'b1) err_cnt++;
         if (tx_send === 1'b1 && !prev_send) begin
            mon_rises++;
            if (mon_idx > 0) check("gap_low_cycles", low_run, GAP + 1);
            mon_idx++;
            check("queue_has_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
            last_byte = tx_data;
            high_run = 1;
         end else if (tx_send === 1'b1) begin
            check("tx_data_stable", tx_data, prev_data);
            high_run++;
         end
         if (tx_send !== 1'b1 && prev_send) begin
            last_high = high_run;
            low_run = 0;
         end
         if (tx_send !== 1'b1) low_run++;
         prev_send = (tx_send === 1'b1);
         prev_data = tx_data;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [95:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic start_frame(input logic [95:0] d, input int n_bytes);
      byte_q_t f;
      f = build_frame(d);
      for (int i = 0; i < n_bytes; i++) exp_q.push_back(f[i]);
      check("idle_before_start", busy, 1'b0);
      strobe(d);
      check("latency_busy_n1", busy, 1'b1);
      check("latency_send_n1", tx_send, 1'b0);
      cycles(1);
      check("latency_send_n2", tx_send, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      int ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (busy === 1'b0) begin
            ok = 1;
            break;
         end
         cycles(1);
      end
      check("idle_reached", ok, 1);
   endtask

   function automatic logic [95:0] rnd96();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      int d0, e0, r0, ok;
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, r0, ok;
      cycles(3);
      check("rst_tx_send", tx_send, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      rst = 1'b1;
      cycles(2);

      // Normal frame
      d0 = done_cnt; e0 = err_cnt; r0 = mon_rises;
      start_frame(96'h0102_0304_0506_0708_090A_0B0C, 15);
      wait_idle(2000);
      cycles(2);
      check("normal_checksum", last_byte, 8'h4D);
      check("normal_done_pulses", done_cnt - d0, 1);
      check("normal_err_pulses", err_cnt - e0, 0);
      check("normal_rises", mon_rises - r0, 15);
      check("normal_queue_empty", exp_q.size(), 0);

      // Checksum wrap
      start_frame({6{16'hFFFF}}, 15);
      wait_idle(2000);
      cycles(2);
      check("wrap_checksum", last_byte, 8'hF3);

      // Drops while busy, including one in the DONE cycle
      start_frame(rnd96(), 15);
      repeat (3) begin
         cycles($urandom_range(5, 40));
         check("busy_for_drop", busy, 1'b1);
         strobe(rnd96());
         exp_drop = sat_inc(exp_drop);
      end
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (frame_done === 1'b1) begin
            ok = 1;
            break;
         end
         cycles(1);
      end
      check("reached_done_state", ok, 1);
      strobe(rnd96());
      exp_drop = sat_inc(exp_drop);
      cycles(5);
      check("drop_count_4", drop_cnt, exp_drop);
      check("no_start_from_drop", busy, 1'b0);
      start_frame(rnd96(), 15);
      wait_idle(2000);

      // Saturation
      stub_delay = 30;
      start_frame(rnd96(), 15);
      for (int i = 0; i < 300; i++) begin
         if (busy !== 1'b1) break;
         strobe(rnd96());
         exp_drop = sat_inc(exp_drop);
      end
      check("drop_saturated", drop_cnt, exp_drop);
      check("drop_is_255", drop_cnt, 8'hFF);
      wait_idle(3000);

      // Timeout on byte 3
      stub_delay = 20;
      withhold_idx = 3;
      d0 = done_cnt; e0 = err_cnt;
      start_frame(rnd96(), 4);
      wait_idle(2000);
      cycles(2);
      check("timeout_high_cycles", last_high, TMO);
      check("timeout_err_pulses", err_cnt - e0, 1);
      check("timeout_done_pulses", done_cnt - d0, 0);
      check("timeout_queue_empty", exp_q.size(), 0);
      withhold_idx = -1;
      d0 = done_cnt;
      start_frame(rnd96(), 15);
      wait_idle(2000);
      cycles(2);
      check("after_timeout_done", done_cnt - d0, 1);

      // Reset during byte 7 WAIT
      r0 = mon_rises;
      start_frame(rnd96(), 8);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (mon_rises - r0 == 8) begin
            ok = 1;
            break;
         end
         cycles(1);
      end
      check("reached_byte7", ok, 1);
      cycles(3);
      rst = 1'b0;
      cycles(1);
      rst = 1'b1;
      exp_drop = 0;
      check("midrst_tx_send", tx_send, 0);
      check("midrst_busy", busy, 0);
      check("midrst_drop_cnt", drop_cnt, exp_drop);
      check("midrst_queue_empty", exp_q.size(), 0);
      cycles(3);
      start_frame(rnd96(), 15);
      wait_idle(2000);

      // Same-cycle tx_done, then a few random-latency frames
      stub_delay = 0;
      d0 = done_cnt;
      start_frame(rnd96(), 15);
      wait_idle(2000);
      for (int k = 0; k < 4; k++) begin
         stub_delay = $urandom_range(0, 6);
         start_frame(rnd96(), 15);
         wait_idle(2000);
      end
      cycles(2);
      check("fast_done_pulses", done_cnt - d0, 5);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_drop_cnt", drop_cnt, exp_drop);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
